// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver (and any future parity-capable
// transmitter): character width, bit-timer width, receiver FSM encoding and
// the even-parity helper.
// Optional feature macro: RX_PARITY_EN adds the PARITY state to the encoding.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int TIMER_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rxState_e;

  // Returns the parity bit that makes the XOR of data plus parity equal 0.
  function automatic logic evenParity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Groups the serial line, the consumer handshake and the status flags of the
// UART receiver.
//   master : the side that drives SerialIn / ReadAck and observes the results
//   slave  : the receiver itself
// Signals: SerialIn, ReadAck, DataOut[7:0], DataReady, CharReceived,
//          FrameError, Overrun, Busy, ParityError (only with RX_PARITY_EN).
// ---------------------------------------------------------------------------
interface uart_rx_if;
  import uart_pkg::*;

  logic                 SerialIn;
  logic                 ReadAck;
  logic [DATA_BITS-1:0] DataOut;
  logic                 DataReady;
  logic                 CharReceived;
  logic                 FrameError;
  logic                 Overrun;
  logic                 Busy;
`ifdef RX_PARITY_EN
  logic                 ParityError;
`endif

  modport master (
`ifdef RX_PARITY_EN
    input  ParityError,
`endif
    output SerialIn, ReadAck,
    input  DataOut, DataReady, CharReceived, FrameError, Overrun, Busy
  );

  modport slave (
`ifdef RX_PARITY_EN
    output ParityError,
`endif
    input  SerialIn, ReadAck,
    output DataOut, DataReady, CharReceived, FrameError, Overrun, Busy
  );

endinterface

// File: rtl/rx_bit_timer.sv
// ---------------------------------------------------------------------------
// rx_bit_timer
// Loadable down-counter that paces the receiver's bit sampling. It stops at
// zero and reports expire_o while it sits there.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   load_i       : load loadValue_i on the next edge (has priority)
//   loadValue_i  : reload value, TIMER_W bits
//   expire_o     : counter has reached zero
// ---------------------------------------------------------------------------
module rx_bit_timer
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] loadValue_i,
  output logic               expire_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == '0);

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver with a single-byte holding register and a
// ready/acknowledge handshake toward the consumer.
// Ports:
//   Clock, Reset : system clock, asynchronous active-high reset
//   bus (slave)  : SerialIn, ReadAck in; DataOut, DataReady, CharReceived,
//                  FrameError, Overrun, Busy (and ParityError) out
// Parameter CLKS_PER_BIT: clock cycles per serial bit (4..65535).
// Optional feature macro: RX_PARITY_EN adds an even-parity bit after the data
// bits and the ParityError pulse.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input logic      Clock,
  input logic      Reset,
  uart_rx_if.slave bus
);

  // First sample lands mid start bit; every later one is a full bit apart.
  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_LOAD = TIMER_W'(CLKS_PER_BIT - 1);

  logic                 sync1_q, rxS_q;
  rxState_e             state_q, state_d;
  logic [2:0]           bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dataOut_q, dataOut_d;
  logic                 dataReady_q, dataReady_d;
  logic                 overrun_q, overrun_d;
  logic                 charReceived_q, frameError_q;
  logic                 timerLoad, timerExpire;
  logic [TIMER_W-1:0]   timerLoadValue;
  logic                 accept, frameErr;
`ifdef RX_PARITY_EN
  logic                 parityBad_q, parityBad_d;
  logic                 parityError_q, parityErr;
`endif

  // The line is asynchronous; both flops idle high so reset never looks
  // like a start bit.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b1;
      rxS_q   <= 1'b1;
    end else begin
      sync1_q <= bus.SerialIn;
      rxS_q   <= sync1_q;
    end
  end

  rx_bit_timer u_timer (
    .clk         (Clock),
    .rst         (Reset),
    .load_i      (timerLoad),
    .loadValue_i (timerLoadValue),
    .expire_o    (timerExpire)
  );

  // Next-state logic: each state waits for the timer, samples rxS_q, and
  // reloads the timer when it moves to a state that needs timing.
  always_comb begin
    state_d        = state_q;
    bitIdx_d       = bitIdx_q;
    shift_d        = shift_q;
    timerLoad      = 1'b0;
    timerLoadValue = FULL_LOAD;
    accept         = 1'b0;
    frameErr       = 1'b0;
`ifdef RX_PARITY_EN
    parityBad_d    = parityBad_q;
    parityErr      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxS_q) begin
          state_d        = START;
          timerLoad      = 1'b1;
          timerLoadValue = HALF_LOAD;
        end
      end
      START: begin
        if (timerExpire) begin
          if (rxS_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bitIdx_d  = '0;
            timerLoad = 1'b1;
          end
        end
      end
      DATA: begin
        if (timerExpire) begin
          shift_d   = {rxS_q, shift_q[DATA_BITS-1:1]};
          timerLoad = 1'b1;
          if (bitIdx_q == 3'(DATA_BITS - 1)) begin
`ifdef RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (timerExpire) begin
          parityBad_d = evenParity(shift_q) ^ rxS_q;
          state_d     = STOP;
          timerLoad   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (timerExpire) begin
`ifdef RX_PARITY_EN
          parityErr = parityBad_q;
`endif
          if (rxS_q) begin
            state_d = IDLE;
`ifdef RX_PARITY_EN
            accept  = !parityBad_q;
`else
            accept  = 1'b1;
`endif
          end else begin
            state_d  = WAIT_HIGH;
            frameErr = 1'b1;
          end
        end
      end
      // A held-low line (break) must go high before a new start is seen.
      WAIT_HIGH: begin
        if (rxS_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding register: an accept always wins over a same-cycle ReadAck.
  always_comb begin
    dataOut_d   = dataOut_q;
    dataReady_d = dataReady_q;
    overrun_d   = overrun_q;
    if (accept) begin
      dataOut_d   = shift_q;
      dataReady_d = 1'b1;
      overrun_d   = bus.ReadAck ? 1'b0 : (overrun_q | dataReady_q);
    end else if (bus.ReadAck) begin
      dataReady_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      bitIdx_q       <= '0;
      shift_q        <= '0;
      dataOut_q      <= '0;
      dataReady_q    <= 1'b0;
      overrun_q      <= 1'b0;
      charReceived_q <= 1'b0;
      frameError_q   <= 1'b0;
`ifdef RX_PARITY_EN
      parityBad_q    <= 1'b0;
      parityError_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      bitIdx_q       <= bitIdx_d;
      shift_q        <= shift_d;
      dataOut_q      <= dataOut_d;
      dataReady_q    <= dataReady_d;
      overrun_q      <= overrun_d;
      charReceived_q <= accept;
      frameError_q   <= frameErr;
`ifdef RX_PARITY_EN
      parityBad_q    <= parityBad_d;
      parityError_q  <= parityErr;
`endif
    end
  end

  assign bus.DataOut      = dataOut_q;
  assign bus.DataReady    = dataReady_q;
  assign bus.CharReceived = charReceived_q;
  assign bus.FrameError   = frameError_q;
  assign bus.Overrun      = overrun_q;
  assign bus.Busy         = (state_q != IDLE);
`ifdef RX_PARITY_EN
  assign bus.ParityError  = parityError_q;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that is the downstream partner of the `TX` transmitter. It recovers 8-bit characters from the `TX` `DataOut` line, which uses the 8N1 format: idle-high, one start bit, 8 data bits LSB first, one stop bit. Each received byte is presented on a holding register with a ready/acknowledge handshake. It sits between the serial line and the consuming logic, and is the loopback target for `TX` in system benches.

## Interface
- `CLKS_PER_BIT`, default 5208: `Clock` cycles per serial bit. Legal range is 4 to 65535.
- `Clock`  in  1  system clock; all logic is rising-edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `SerialIn`  in  1  serial line; asynchronous to `Clock`; idle-high.
- `ReadAck`  in  1  consumer has taken `DataOut`; clears `DataReady`.
- `DataOut`  out  8  last accepted character.
- `DataReady`  out  1  `DataOut` holds an unread character.
- `CharReceived`  out  1  one-cycle pulse when `DataOut` is loaded.
- `FrameError`  out  1  one-cycle pulse when the stop bit is sampled low.
- `Overrun`  out  1  sticky flag: a character arrived while `DataReady` was 1. Cleared by `ReadAck`.
- `Busy`  out  1  high in every state except IDLE.
- `ParityError`  out  1  one-cycle pulse on a parity mismatch. Present only under `RX_PARITY_EN`.

## Operation
- `SerialIn` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized bit `rx_s`.
- Bit timer: a 16-bit down-counter. It reloads on every state entry.
- FSM states: IDLE, START, DATA, PARITY (only under `RX_PARITY_EN`), STOP, WAIT_HIGH.
  - IDLE: when `rx_s`=0, go to START and load the timer with `CLKS_PER_BIT/2 - 1` (integer division).
  - START: on timer expiry, sample `rx_s`.
    - If 1: false start; return to IDLE.
    - If 0: go to DATA with bit index 0 and load the timer with `CLKS_PER_BIT - 1`.
  - DATA: on each expiry, shift `rx_s` into the MSB of the shift register, so data arrives LSB first. After index 7, go to PARITY or STOP.
  - PARITY: sample one bit.
  - STOP: sample `rx_s`.
    - If 1: go to IDLE.
    - If 0: pulse `FrameError`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE once `rx_s`=1. This prevents a break condition from retriggering.
- Accept rule: on a valid stop bit (with parity OK when enabled):
  - load `DataOut` and pulse `CharReceived`;
  - set `DataReady`;
  - if `DataReady` was already 1, set `Overrun` and overwrite `DataOut` with the new byte.
- `ReadAck` clears `DataReady` and `Overrun` on the next edge. If `ReadAck` falls in the same cycle as an accept, the accept wins: `DataReady` stays 1 and `Overrun` is not set.
- `ReadAck` while `DataReady`=0 has no effect.

## Timing
- Reset values:
  - `DataOut`=0x00, `DataReady`=0, `CharReceived`=0, `FrameError`=0, `Overrun`=0, `Busy`=0, `ParityError`=0.
  - FSM in IDLE; synchronizer at 1.
- Start detection: at most 3 cycles after `SerialIn` falls (2 synchronizer cycles plus 1 IDLE cycle).
- Sample points: mid-bit, at start-edge-detect + `CLKS_PER_BIT/2` + k·`CLKS_PER_BIT`.
- Pulses: `CharReceived` and `FrameError` assert in the cycle after the stop-bit sample and last exactly one cycle.
- `Busy` deasserts in the same cycle the FSM re-enters IDLE. A new start bit is accepted immediately after a good stop sample; no extra idle time is required.
- Reset asserted mid-character: all state is forced to reset values immediately; the partial byte is lost.
- Tolerated baud mismatch: ±4 % across 10 bits.

## Configuration
- `RX_PARITY_EN` defined:
  - a PARITY state follows DATA, expecting even parity (the XOR of the 8 data bits plus the parity bit must be 0);
  - on a mismatch, pulse `ParityError` alongside the stop-sample timing, discard the byte, and still check the stop bit;
  - the `ParityError` port exists.
- `RX_PARITY_EN` undefined: no PARITY state, no `ParityError` port. Pure 8N1, matching `TX`.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding;
  - constants `DATA_BITS`=8 and `TIMER_W`=16;
  - parity-function helper, shared with any future parity-capable `TX`.
- One sub-module, `rx_bit_timer`: the loadable down-counter with an `expire` output. The synchronizer, FSM and holding register stay in `uart_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
1. Send 0xCE as 8N1 -> one `CharReceived` pulse; `DataOut`=0xCE; `DataReady`=1; `FrameError`=0.
2. Send 0xEF, 0xDE, 0xAD back-to-back with `ReadAck` after each -> 3 pulses, correct bytes, `Overrun` never set.
3. Send 0xBE, then 0xEF with no `ReadAck` -> `DataOut`=0xEF, `Overrun`=1; one `ReadAck` clears both `DataReady` and `Overrun`.
4. Glitch `SerialIn` low for 5 cycles only -> FSM returns to IDLE; no `CharReceived` pulse; `Busy` pulses high and then returns low.
5. Send 0x55 with the stop bit low, then hold the line low for 40 cycles, then high -> one `FrameError` pulse; `DataReady` stays 0; no retrigger until the line goes high.
6. Assert `Reset` during bit 4 of 0xA5, then send 0x3C -> outputs at reset values during reset; afterwards `DataOut`=0x3C. With `RX_PARITY_EN` defined, also send 0x01 with parity bit 0 -> one `ParityError` pulse and no accept.
